// File: rtl/prim_decoder_pkg.sv
// prim_decoder_pkg: shared mode encoding and parameter limits for the decoder pipe
package prim_decoder_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT,
    DEC_THERMO,
    DEC_ACCUM,
    DEC_RSVD
  } dec_mode_e;

  function automatic int max_bin_w();
    return 6;
  endfunction

endpackage

// File: rtl/prim_decoder_core.sv
// prim_decoder_core: combinational one-hot / thermometer / range decode of a binary code
module prim_decoder_core #(
  parameter int BIN_W   = 3,
  parameter int NUM_OUT = 2 ** BIN_W
) (
  input  logic [BIN_W-1:0]   code_i,
  output logic [NUM_OUT-1:0] onehot_o,
  output logic [NUM_OUT-1:0] thermo_o,
  output logic               err_o
);

  // a thermometer bit is set when the code lands at or above its position
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_bit
    assign onehot_o[g] = code_i == BIN_W'(g);
    assign thermo_o[g] = |onehot_o[NUM_OUT-1:g];
  end

  assign err_o = {1'b0, code_i} >= (BIN_W + 1)'(NUM_OUT);

endmodule

// File: rtl/prim_decoder_pipe.sv
// prim_decoder_pipe: registered binary-to-N decoder with skid buffer and sticky accumulate mode
module prim_decoder_pipe
  import prim_decoder_pkg::*;
#(
  parameter int BIN_W   = 3,
  parameter int NUM_OUT = 2 ** BIN_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BIN_W-1:0]   i_bin,
  input  logic [1:0]         i_mode,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_clear,
  output logic [NUM_OUT-1:0] o_dec,
  output logic               o_err,
  output logic               o_valid,
  input  logic               i_ready
);

  if (BIN_W < 1 || BIN_W > max_bin_w() || NUM_OUT < 2 || NUM_OUT > (1 << BIN_W)) begin : g_bad_param
    $error("prim_decoder_pipe: illegal BIN_W=%0d / NUM_OUT=%0d", BIN_W, NUM_OUT);
  end

  dec_mode_e          mode;
  logic [NUM_OUT-1:0] onehot, thermo, new_dec, acc_base;
  logic               err, accept, consume, is_acc;
  logic [NUM_OUT-1:0] acc_q, acc_d, out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
  logic               out_err_q, out_err_d, out_vld_q, out_vld_d;
  logic               skid_err_q, skid_err_d, skid_vld_q, skid_vld_d;

  prim_decoder_core #(
    .BIN_W  (BIN_W),
    .NUM_OUT(NUM_OUT)
  ) u_core (
    .code_i  (i_bin),
    .onehot_o(onehot),
    .thermo_o(thermo),
    .err_o   (err)
  );

  // decode the incoming transaction; a coincident clear wipes the accumulator before it is ORed in
  always_comb begin
    mode     = dec_mode_e'(i_mode);
    is_acc   = mode == DEC_ACCUM;
    accept   = i_valid & ~skid_vld_q;
    consume  = out_vld_q & i_ready;
    acc_base = i_clear ? '0 : acc_q;
    new_dec  = err ? '0 : mode == DEC_THERMO ? thermo : is_acc ? acc_base | onehot : onehot;
    acc_d    = (accept & is_acc & ~err) ? acc_base | onehot : acc_base;
  end

  // output register refills from the skid entry first, else straight from the input; a stalled accept parks in skid
  always_comb begin
    out_dec_d  = out_dec_q;
    out_err_d  = out_err_q;
    out_vld_d  = out_vld_q;
    skid_dec_d = skid_dec_q;
    skid_err_d = skid_err_q;
    skid_vld_d = skid_vld_q;
    if (consume | ~out_vld_q) begin
      out_vld_d  = skid_vld_q | accept;
      out_dec_d  = skid_vld_q ? skid_dec_q : accept ? new_dec : out_dec_q;
      out_err_d  = skid_vld_q ? skid_err_q : accept ? err : out_err_q;
      skid_vld_d = 1'b0;
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_dec_d = new_dec;
      skid_err_d = err;
    end
  end

  // state registers, all cleared by reset so in-flight data is discarded
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q      <= '0;
      out_dec_q  <= '0;
      out_err_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      skid_dec_q <= '0;
      skid_err_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      out_dec_q  <= out_dec_d;
      out_err_q  <= out_err_d;
      out_vld_q  <= out_vld_d;
      skid_dec_q <= skid_dec_d;
      skid_err_q <= skid_err_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign o_ready = ~skid_vld_q;
  assign o_dec   = out_dec_q;
  assign o_err   = out_err_q;
  assign o_valid = out_vld_q;

endmodule

// File: tb/tb_prim_decoder_pipe.sv
// tb_prim_decoder_pipe: directed and random checks of two decoder configurations against a FIFO-level model
module tb_prim_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst, vld, clr, rdy;
  logic [2:0] bin;
  logic [1:0] mode;
  logic       rdy8, err8, ov8, rdy5, err5, ov5;
  logic [7:0] dec8;
  logic [4:0] dec5;
  int         tests = 0, fails = 0;
  int         cnt[2];
  logic [7:0] acc[2];
  logic [8:0] q8[$], q5[$];

  always #5 clk = ~clk;

  prim_decoder_pipe #(.BIN_W(3), .NUM_OUT(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_bin(bin), .i_mode(mode), .i_valid(vld), .o_ready(rdy8),
    .i_clear(clr), .o_dec(dec8), .o_err(err8), .o_valid(ov8), .i_ready(rdy)
  );

  prim_decoder_pipe #(.BIN_W(3), .NUM_OUT(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_bin(bin), .i_mode(mode), .i_valid(vld), .o_ready(rdy5),
    .i_clear(clr), .o_dec(dec5), .o_err(err5), .o_valid(ov5), .i_ready(rdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle, advance the model of each DUT as a two-deep FIFO, then compare
  task automatic step(input logic r, input logic v, input logic [2:0] b, input logic [1:0] m,
                      input logic c, input logic rd);
    rst = r; vld = v; bin = b; mode = m; clr = c; rdy = rd;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      int         n = d ? 5 : 8;
      logic       cons, ok;
      logic [7:0] a, w;
      logic [8:0] head;
      if (r) begin
        cnt[d] = 0;
        acc[d] = 8'h0;
        if (d) q5.delete(); else q8.delete();
      end else begin
        cons = cnt[d] > 0 && rd;
        ok   = v && cnt[d] < 2;
        if (cons) begin
          if (d) void'(q5.pop_front()); else void'(q8.pop_front());
        end
        a = c ? 8'h0 : acc[d];
        w = (b >= n) ? 8'h0 : (m == 1) ? 8'((2 << b) - 1) : (m == 2) ? (a | 8'(1 << b)) : 8'(1 << b);
        if (ok) begin
          if (d) q5.push_back({b >= n, w}); else q8.push_back({b >= n, w});
        end
        if (ok && m == 2 && b < n) a = a | 8'(1 << b);
        acc[d] = a;
        cnt[d] = cnt[d] + int'(ok) - int'(cons);
      end
      head = d ? ((q5.size() > 0) ? q5[0] : 9'h0) : ((q8.size() > 0) ? q8[0] : 9'h0);
      check($sformatf("valid%0d", n), 32'(d ? ov5 : ov8), 32'(cnt[d] > 0));
      check($sformatf("ready%0d", n), 32'(d ? rdy5 : rdy8), 32'(cnt[d] < 2));
      if (cnt[d] > 0) begin
        check($sformatf("dec%0d", n), d ? 32'(dec5) : 32'(dec8), 32'(head[7:0]));
        check($sformatf("err%0d", n), 32'(d ? err5 : err8), 32'(head[8]));
      end
    end
  endtask

  initial begin
    int n_acc = 0, cyc = 0;
    logic v;
    // reset held two cycles with valid asserted
    step(1, 1, 3'd5, 2'd2, 0, 1);
    step(1, 1, 3'd5, 2'd2, 0, 1);
    check("rst_dec", 32'(dec8), 32'h0);
    check("rst_ready", 32'(rdy8), 32'h1);
    // one-hot streaming
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 3'(k), 2'd0, 0, 1);
      check($sformatf("onehot%0d", k), 32'(dec8), 32'(1 << k));
    end
    // thermometer
    step(0, 1, 3'd3, 2'd1, 0, 1); check("thermo3", 32'(dec8), 32'h0F);
    step(0, 1, 3'd0, 2'd1, 0, 1); check("thermo0", 32'(dec8), 32'h01);
    step(0, 1, 3'd7, 2'd1, 0, 1); check("thermo7", 32'(dec8), 32'hFF);
    // accumulate with clear
    step(0, 1, 3'd1, 2'd2, 0, 1); check("acc1", 32'(dec8), 32'h02);
    step(0, 1, 3'd4, 2'd2, 0, 1); check("acc4", 32'(dec8), 32'h12);
    step(0, 1, 3'd6, 2'd2, 0, 1); check("acc6", 32'(dec8), 32'h52);
    step(0, 1, 3'd0, 2'd2, 1, 1); check("acc_clr", 32'(dec8), 32'h01);
    step(0, 1, 3'd5, 2'd0, 0, 1); check("oh5", 32'(dec8), 32'h20);
    step(0, 1, 3'd2, 2'd2, 0, 1); check("acc2", 32'(dec8), 32'h05);
    step(0, 0, 3'd0, 2'd0, 0, 1);
    // back-pressure into the skid entry
    step(0, 1, 3'd2, 2'd0, 0, 0); check("bp_first", 32'(dec8), 32'h04);
    step(0, 1, 3'd3, 2'd0, 0, 0); check("bp_hold", 32'(dec8), 32'h04);
    check("bp_ready", 32'(rdy8), 32'h0);
    step(0, 0, 3'd0, 2'd0, 0, 1); check("bp_skid", 32'(dec8), 32'h08);
    check("bp_ready_back", 32'(rdy8), 32'h1);
    step(0, 0, 3'd0, 2'd0, 0, 1); check("bp_empty", 32'(ov8), 32'h0);
    // out of range on the five-output instance
    step(0, 0, 3'd0, 2'd0, 1, 1);
    step(0, 1, 3'd6, 2'd2, 0, 1);
    check("oor_err", 32'(err5), 32'h1); check("oor_dec", 32'(dec5), 32'h0);
    step(0, 1, 3'd1, 2'd2, 0, 1);
    check("oor_next_err", 32'(err5), 32'h0); check("oor_next_dec", 32'(dec5), 32'h02);
    // random traffic with random back-pressure
    while (n_acc < 1000 && cyc < 20000) begin
      v = $urandom_range(0, 3) != 0;
      if (v && cnt[0] < 2) n_acc++;
      step(0, v, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      cyc++;
    end
    check("accepted", 32'(n_acc), 32'd1000);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd0, 2'd0, 0, 1);
    check("drained", 32'(ov8), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
